// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared types/constants for pipe_hazard_ctrl        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int VLAT_W   = 4;
  localparam int MAX_VLAT = 8;
  localparam int RA_W     = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VBUSY = 1'b1
  } state_t;

  // Effective latency: zero requests mean one cycle, oversize requests saturate.
  function automatic logic [VLAT_W-1:0] clamp_vlat(input logic [VLAT_W-1:0] v);
    logic [VLAT_W-1:0] r;
    if (v == '0)
      r = VLAT_W'(1);
    else if (v > VLAT_W'(MAX_VLAT))
      r = VLAT_W'(MAX_VLAT);
    else
      r = v;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_vlat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vlat_counter : loadable down-counter tracking remaining VALU cycles|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vlat_counter
  import pipe_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [VLAT_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              last_o,
  output logic              zero_o
);

  logic [VLAT_W-1:0] cnt_q;
  logic [VLAT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - VLAT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == VLAT_W'(1));
  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/flush sequencer for 5-stage pipe + VALU   |
// | Optional perf counters: PIPE_HAZARD_CTRL_PERF_EN.   Rev 1.0        |
// +--------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              start_i,
  input  logic [RA_W-1:0]   id_rs1_i,
  input  logic [RA_W-1:0]   id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic              ex_mem_read_i,
  input  logic [RA_W-1:0]   ex_rd_i,
  input  logic              ex_vop_i,
  input  logic [VLAT_W-1:0] ex_vlat_i,
  input  logic              mem_branch_taken_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_write_o,
  output logic              id_ex_bubble_o,
  output logic              ex_mem_bubble_o,
  output logic              valu_done_o,
  output logic              busy_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       vop_count_o,
  output logic [31:0]       lu_stalls_o
`endif
);

  state_t            state_q;
  state_t            state_d;
  logic [VLAT_W-1:0] w_lat;
  logic              w_lu_hazard;
  logic              w_lu_stall;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_last;
  logic              w_zero;

  assign w_lat = clamp_vlat(ex_vlat_i);

  assign w_lu_hazard = ex_mem_read_i && (ex_rd_i != '0) &&
                       (((ex_rd_i == id_rs1_i) && id_use_rs1_i) ||
                        ((ex_rd_i == id_rs2_i) && id_use_rs2_i));

  vlat_counter u_vlat_counter (
    .clk_i      (clk_i),
    .rst_ni     (start_i),
    .load_i     (w_cnt_load),
    .load_val_i (w_lat - VLAT_W'(1)),
    .dec_i      (w_cnt_dec),
    .last_o     (w_last),
    .zero_o     (w_zero)
  );

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Outputs are gated by start_i so the pipeline is frozen during reset.
  always_comb begin
    state_d         = state_q;
    pc_write_o      = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_write_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_bubble_o = 1'b0;
    valu_done_o     = 1'b0;
    busy_o          = 1'b0;
    w_cnt_load      = 1'b0;
    w_cnt_dec       = 1'b0;
    w_lu_stall      = 1'b0;
    if (start_i) begin
      unique case (state_q)
        IDLE: begin
          if (mem_branch_taken_i) begin
            pc_write_o      = 1'b1;
            if_id_write_o   = 1'b1;
            if_id_flush_o   = 1'b1;
            id_ex_write_o   = 1'b1;
            id_ex_bubble_o  = 1'b1;
            ex_mem_bubble_o = 1'b1;
          end else if (ex_vop_i && (w_lat >= VLAT_W'(2))) begin
            ex_mem_bubble_o = 1'b1;
            w_cnt_load      = 1'b1;
            state_d         = VBUSY;
          end else if (w_lu_hazard) begin
            id_ex_write_o   = 1'b1;
            id_ex_bubble_o  = 1'b1;
            w_lu_stall      = 1'b1;
          end else begin
            pc_write_o      = 1'b1;
            if_id_write_o   = 1'b1;
            id_ex_write_o   = 1'b1;
            valu_done_o     = ex_vop_i;
          end
        end
        VBUSY: begin
          busy_o    = 1'b1;
          w_cnt_dec = 1'b1;
          if (w_last) begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
            id_ex_write_o = 1'b1;
            valu_done_o   = 1'b1;
            state_d       = IDLE;
          end else if (!w_zero) begin
            ex_mem_bubble_o = 1'b1;
          end else begin
            // Counter already drained: unreachable, recover to IDLE.
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_branch_in_vbusy: assert property (@(posedge clk_i) disable iff (!start_i)
    !((state_q == VBUSY) && mem_branch_taken_i));
`endif

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] vop_count_q;
  logic [31:0] lu_stalls_q;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      stall_cycles_q <= '0;
      vop_count_q    <= '0;
      lu_stalls_q    <= '0;
    end else begin
      if (!pc_write_o && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (valu_done_o && (vop_count_q != '1))
        vop_count_q <= vop_count_q + 32'd1;
      if (w_lu_stall && (lu_stalls_q != '1))
        lu_stalls_q <= lu_stalls_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign vop_count_o    = vop_count_q;
  assign lu_stalls_o    = lu_stalls_q;
`endif

endmodule
`default_nettype wire
